// File: rtl/pmem_pkg.sv
// Shared types and constants for the instruction memory controller: FSM state
// encoding, default geometry and the optional boot image bytes.
package pmem_pkg;

  localparam int PMEM_DEPTH   = 1024;
  localparam int PMEM_ADDR_W  = 16;
  localparam int PMEM_INSTR_W = 32;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    RUN   = 2'd1,
    LOAD  = 2'd2
  } pmem_state_t;

  // addi r1,r0,10 ; add r2,r0,r1 ; sub r3,r0,r1 -- stored big-endian from byte 0
  localparam int BOOT_LEN = 12;
  localparam logic [8*BOOT_LEN-1:0] BOOT_IMAGE = 96'h8020000A_04400800_0C600800;

  function automatic logic [7:0] boot_byte(input int idx);
    logic [7:0] b;
    logic [6:0] lsb;
    b   = 8'h00;
    lsb = 7'd0;
    if (idx >= 0 && idx < BOOT_LEN) begin
      lsb = 7'(8 * (BOOT_LEN - 1 - idx));
      b   = BOOT_IMAGE[lsb +: 8];
    end
    return b;
  endfunction

endpackage

// File: rtl/instr_byte_ram.sv
// Byte-wide storage with one synchronous write port and NB combinational read
// ports returning bytes rd_base, rd_base+1, ... wrapped modulo DEPTH.
module instr_byte_ram #(
  parameter int DEPTH = 1024,
  parameter int NB    = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [7:0]           wr_data,
  input  logic [AW-1:0]        rd_base,
  output logic [NB-1:0][7:0]   rd_bytes
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // DEPTH is a power of two, so AW-bit addition wraps exactly modulo DEPTH
  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_rd
      logic [AW-1:0] idx;
      assign idx          = rd_base + AW'(gi);
      assign rd_bytes[gi] = mem[idx];
    end
  endgenerate

endmodule

// File: rtl/instr_memory_ctrl.sv
// Instruction memory controller: CLEAR -> RUN <-> LOAD, big-endian fetch port
// and byte-serial load port. Define PMEM_BOOT_IMAGE_EN to preload a boot image.
module instr_memory_ctrl
  import pmem_pkg::*;
#(
  parameter int DEPTH   = PMEM_DEPTH,
  parameter int ADDR_W  = PMEM_ADDR_W,
  parameter int INSTR_W = PMEM_INSTR_W
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_fetch_req,
  input  logic [ADDR_W-1:0]  i_fetch_addr,
  input  logic               i_stall,
  output logic [INSTR_W-1:0] o_instruction,
  output logic               o_fetch_valid,
  output logic               o_misaligned,
  output logic               o_busy,
  input  logic               i_ld_start,
  input  logic [ADDR_W-1:0]  i_ld_base,
  input  logic               i_ld_valid,
  input  logic [7:0]         i_ld_byte,
  input  logic               i_ld_last,
  output logic               o_ld_ready
);

  localparam int NB  = INSTR_W / 8;
  localparam int LAW = $clog2(DEPTH);

  pmem_state_t        state_reg;
  logic [LAW-1:0]     clr_ptr_reg;
  logic [LAW-1:0]     wr_ptr_reg;
  logic [INSTR_W-1:0] instr_reg;
  logic               valid_reg;
  logic               misaligned_reg;
  logic               busy_reg;
  logic               ld_ready_reg;

  logic [LAW-1:0]     fetch_a;
  logic               fetch_misaligned;
  logic [NB-1:0][7:0] rd_bytes;
  logic [INSTR_W-1:0] fetch_word;
  logic [7:0]         clear_byte;
  logic               wr_en;
  logic [LAW-1:0]     wr_addr;
  logic [7:0]         wr_data;

  assign fetch_a          = i_fetch_addr[LAW-1:0];
  assign fetch_misaligned = (int'(fetch_a) % NB) != 0;

`ifdef PMEM_BOOT_IMAGE_EN
  assign clear_byte = boot_byte(int'(clr_ptr_reg));
`else
  assign clear_byte = 8'h00;
`endif

  // Byte 0 of the fetch lands in the most significant lane
  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_word
      assign fetch_word[INSTR_W-1-8*gi -: 8] = rd_bytes[gi];
    end
    if (ADDR_W > LAW) begin : g_hi_addr
      logic unused_hi_addr;
      assign unused_hi_addr = ^{i_fetch_addr[ADDR_W-1:LAW], i_ld_base[ADDR_W-1:LAW]};
    end
  endgenerate

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = wr_ptr_reg;
    wr_data = i_ld_byte;
    if (!i_rst) begin
      case (state_reg)
        CLEAR: begin
          wr_en   = 1'b1;
          wr_addr = clr_ptr_reg;
          wr_data = clear_byte;
        end
        LOAD:    wr_en = i_ld_valid;
        default: wr_en = 1'b0;
      endcase
    end
  end

  instr_byte_ram #(
    .DEPTH (DEPTH),
    .NB    (NB),
    .AW    (LAW)
  ) u_ram (
    .clk      (i_clk),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_base  (fetch_a),
    .rd_bytes (rd_bytes)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg      <= CLEAR;
      clr_ptr_reg    <= '0;
      wr_ptr_reg     <= '0;
      instr_reg      <= '0;
      valid_reg      <= 1'b0;
      misaligned_reg <= 1'b0;
      busy_reg       <= 1'b1;
      ld_ready_reg   <= 1'b0;
    end else begin
      case (state_reg)
        CLEAR: begin
          valid_reg      <= 1'b0;
          misaligned_reg <= 1'b0;
          clr_ptr_reg    <= clr_ptr_reg + LAW'(1);
          if (clr_ptr_reg == LAW'(DEPTH - 1)) begin
            state_reg <= RUN;
            busy_reg  <= 1'b0;
          end
        end

        RUN: begin
          if (!i_stall) begin
            if (i_fetch_req) begin
              instr_reg      <= fetch_word;
              valid_reg      <= 1'b1;
              misaligned_reg <= fetch_misaligned;
            end else begin
              valid_reg      <= 1'b0;
              misaligned_reg <= 1'b0;
            end
          end
          // The fetch above is served from pre-load contents in the same cycle
          if (i_ld_start) begin
            state_reg    <= LOAD;
            wr_ptr_reg   <= i_ld_base[LAW-1:0];
            busy_reg     <= 1'b1;
            ld_ready_reg <= 1'b1;
          end
        end

        LOAD: begin
          valid_reg      <= 1'b0;
          misaligned_reg <= 1'b0;
          if (i_ld_valid) begin
            wr_ptr_reg <= wr_ptr_reg + LAW'(1);
            if (i_ld_last) begin
              state_reg    <= RUN;
              busy_reg     <= 1'b0;
              ld_ready_reg <= 1'b0;
            end
          end
        end

        default: begin
          state_reg    <= CLEAR;
          clr_ptr_reg  <= '0;
          busy_reg     <= 1'b1;
          ld_ready_reg <= 1'b0;
          valid_reg    <= 1'b0;
        end
      endcase
    end
  end

  assign o_instruction = instr_reg;
  assign o_fetch_valid = valid_reg;
  assign o_misaligned  = misaligned_reg;
  assign o_busy        = busy_reg;
  assign o_ld_ready    = ld_ready_reg;

endmodule
